// File: rtl/rv32_mem_pkg.sv
// Shared RV32 load/store encodings, MEM-stage FSM states and the store-side
// formatting helpers used by memory_stage.
package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~a[0];
            2'b10:   return (a == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_SB:   return {4{d[7:0]}};
            F3_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_SB:   return 4'b0001 << a;
            F3_SH:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data alignment: picks the addressed byte/halfword from the read word
// and sign- or zero-extends it according to funct3.
module mem_load_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   result_o = rdata_i;
            F3_LBU:  result_o = {24'h0, byte_sel};
            F3_LHU:  result_o = {16'h0, half_sel};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// RV32 MEM stage: turns EX/MEM load/store ops into a req/gnt/rvalid data-bus
// access, stalls upstream while it is outstanding, and drives the MEM/WB register.
module memory_stage
    import rv32_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic [31:0] alu_res,
    input  logic [31:0] opb_datain,
    input  logic [1:0]  mem_reg_in,
    input  logic [31:0] next_sel_addr,
    input  logic [31:0] pre_address_in,
    input  logic [31:0] instruction_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wmask,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        wb_valid_out,
    output logic        mem_err_out,
    output logic [31:0] load_data_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] next_sel_address,
    output logic [31:0] pre_address_out,
    output logic [31:0] instruction_out,
    output logic [1:0]  mem_reg_out
);

    mem_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;

    logic        wb_valid_q, wb_valid_d;
    logic        err_q, err_d;
    logic [31:0] ld_q, ld_d;
    logic [31:0] alu_q, nsa_q, pre_q, instr_q;
    logic [1:0]  mreg_q;

    logic [2:0]  funct3;
    logic        is_load, is_store, legal, aligned, op, err, stall;
    logic [31:0] ld_aligned;

    assign funct3   = instruction_in[14:12];
    assign is_load  = load_in & ~store_in;
    assign is_store = store_in & ~load_in;
    assign legal    = (is_load & load_f3_ok(funct3)) | (is_store & store_f3_ok(funct3));
    assign aligned  = addr_aligned(funct3[1:0], alu_res[1:0]);
    assign op       = valid_in & legal & aligned;
    assign err      = valid_in & (load_in | store_in) & ~op;

    mem_load_align u_align (
        .rdata_i  (dmem_rdata),
        .addr_i   (off_q),
        .funct3_i (f3_q),
        .result_o (ld_aligned)
    );

    // Bubble on every stalled edge falls out of the wb_valid_d/err_d defaults.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        we_d       = we_q;
        f3_d       = f3_q;
        off_d      = off_q;
        stall      = 1'b0;
        wb_valid_d = 1'b0;
        err_d      = 1'b0;
        ld_d       = '0;

        case (state_q)
            IDLE: begin
                if (op) begin
                    stall   = 1'b1;
                    state_d = REQ;
                    addr_d  = {alu_res[31:2], 2'b00};
                    wdata_d = is_store ? store_wdata(funct3, opb_datain) : '0;
                    wmask_d = is_store ? store_mask(funct3, alu_res[1:0]) : '0;
                    we_d    = is_store;
                    f3_d    = funct3;
                    off_d   = alu_res[1:0];
                end else begin
                    wb_valid_d = valid_in;
                    err_d      = err;
                end
            end
            REQ: begin
                if (dmem_gnt && we_q) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    we_d       = 1'b0;
                    wmask_d    = '0;
                end else if (dmem_gnt) begin
                    stall   = 1'b1;
                    state_d = WAIT;
                end else begin
                    stall = 1'b1;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    ld_d       = ld_aligned;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            ld_q       <= '0;
            alu_q      <= '0;
            nsa_q      <= '0;
            pre_q      <= '0;
            instr_q    <= '0;
            mreg_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            wb_valid_q <= wb_valid_d;
            err_q      <= err_d;
            ld_q       <= ld_d;
            alu_q      <= alu_res;
            nsa_q      <= next_sel_addr;
            pre_q      <= pre_address_in;
            instr_q    <= instruction_in;
            mreg_q     <= mem_reg_in;
        end
    end

    assign dmem_req         = (state_q == REQ);
    assign dmem_we          = we_q;
    assign dmem_addr        = addr_q;
    assign dmem_wdata       = wdata_q;
    assign dmem_wmask       = wmask_q;
    assign mem_stall        = stall & ~rst;
    assign wb_valid_out     = wb_valid_q;
    assign mem_err_out      = err_q;
    assign load_data_out    = ld_q;
    assign alu_res_out      = alu_q;
    assign next_sel_address = nsa_q;
    assign pre_address_out  = pre_q;
    assign instruction_out  = instr_q;
    assign mem_reg_out      = mreg_q;

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-002 valid_in, load_in, store_in: input 1 each; instruction valid, load op, store op (from EX/MEM register).
REQ-003 alu_res, opb_datain: input 32 each; effective address, store source data.
REQ-004 mem_reg_in input 2; next_sel_addr, pre_address_in, instruction_in input 32 each; pass-through fields; funct3 = instruction_in[14:12].
REQ-005 dmem_req, dmem_we output 1; dmem_addr output 32 (word-aligned, [1:0]=0); dmem_wdata output 32; dmem_wmask output 4.
REQ-006 dmem_gnt, dmem_rvalid input 1; dmem_rdata input 32.
REQ-007 mem_stall output 1; holds the upstream EX/MEM register while high.
REQ-008 wb_valid_out, mem_err_out output 1; load_data_out, alu_res_out, next_sel_address, pre_address_out, instruction_out output 32; mem_reg_out output 2 (MEM/WB register).

Function
REQ-009 FSM states SHALL be IDLE, REQ, WAIT.
REQ-010 op = valid_in & (load_in ^ store_in) & legal & aligned; err = valid_in & (load_in|store_in) & !(that).
REQ-011 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; load_in&store_in both high is illegal.
REQ-012 Aligned: halfword needs alu_res[0]=0; word needs alu_res[1:0]=0; byte always aligned.
REQ-013 IDLE & op: mem_stall=1; next edge latches address/data/mask/funct3/we, go REQ.
REQ-014 REQ: dmem_req=1, bus fields stable; if !dmem_gnt stay REQ, mem_stall=1.
REQ-015 REQ & gnt & store: mem_stall=0; next edge -> IDLE, MEM/WB captures with wb_valid_out=1.
REQ-016 REQ & gnt & load: mem_stall=1; next edge -> WAIT, dmem_req=0.
REQ-017 WAIT & !rvalid: mem_stall=1; WAIT & rvalid: mem_stall=0; next edge -> IDLE, MEM/WB captures extended load data.
REQ-018 IDLE & !op (non-memory, error, or invalid): mem_stall=0; MEM/WB captures directly; wb_valid_out=valid_in; mem_err_out=err; no bus access.
REQ-019 Any edge where mem_stall=1 SHALL load a bubble: wb_valid_out=0, mem_err_out=0.
REQ-020 Latency edge-to-MEM/WB: non-mem 1 cycle; store min 2; load min 3; each gnt/rvalid wait cycle adds 1.
REQ-021 Store data: SB byte replicated x4; SH halfword x2; SW unchanged.
REQ-022 Store mask: SB 0001<<a[1:0]; SH 0011<<a[1:0]; SW 1111.
REQ-023 Loads: byte/halfword selected by a[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-024 load_data_out=0 for stores/non-loads; other fields pass through.
REQ-025 dmem_rvalid outside WAIT and dmem_gnt outside REQ SHALL be ignored.

Reset
REQ-026 rst SHALL force IDLE, dmem_req=0, dmem_we=0, dmem_wmask=0, dmem_addr/wdata=0, all MEM/WB outputs 0, mem_stall=0.
REQ-027 rst mid-access (REQ/WAIT) SHALL abandon the access; no wb_valid_out pulse follows.

Structure
REQ-028 Package rv32_mem_pkg SHALL hold the funct3 load/store constants and the FSM state enum.
REQ-029 One combinational sub-module, mem_load_align (rdata, addr[1:0], funct3 -> 32-bit result), SHALL implement REQ-023.

Verification
REQ-030 SW addr 0x100, data 0xDEADBEEF, gnt immediate -> dmem_addr 0x100, wmask 1111, wdata 0xDEADBEEF, wb_valid_out 2 cycles later.
REQ-031 SB addr 0x103, data 0x000000A5 -> wmask 1000, wdata 0xA5A5A5A5.
REQ-032 LB addr 0x102, rdata 0x0080FF00, rvalid after 3 wait cycles -> load_data_out 0xFFFFFF80, mem_stall high throughout, wb_valid_out once.
REQ-033 LHU addr 0x101 -> no dmem_req, mem_err_out=1, wb_valid_out=1, no stall.
REQ-034 LW, gnt withheld 4 cycles -> req, addr stable throughout; rst asserted in WAIT -> IDLE, all outputs 0, no wb_valid_out.
REQ-035 ADD (load_in=store_in=0) back-to-back -> one MEM/WB capture per cycle, mem_stall never high.
